// File: rtl/led7_pkg.sv
// ----------------------------------------------------------------------------
// led7_pkg
// Shared types and constants for the multiplexed 7-segment scan driver.
//   nibble_t : one hex digit (4 bits)
//   seg_t    : active-low segment vector, segments a..g on bits 0..6
//   SEG_OFF  : all segments dark
//   GLYPHS   : 16-entry hex glyph table, indexed by nibble value
// ----------------------------------------------------------------------------
package led7_pkg;

    typedef logic [3:0] nibble_t;
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_OFF = 7'h7F;

    // Packed so that GLYPHS[n] is the glyph for nibble n; listed F down to 0.
    localparam logic [15:0][6:0] GLYPHS = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

endpackage

// File: rtl/led7_hex_decode.sv
// ----------------------------------------------------------------------------
// led7_hex_decode
// Purely combinational hex-nibble to active-low 7-segment glyph decoder.
// Ports:
//   nibble : input  hex digit 0..F
//   seg_n  : output active-low segments a..g on bits 0..6
// ----------------------------------------------------------------------------
import led7_pkg::*;

module led7_hex_decode (
    input  nibble_t nibble,
    output seg_t    seg_n
);

    assign seg_n = GLYPHS[nibble];

endmodule

// File: rtl/led7_scan_driver.sv
// ----------------------------------------------------------------------------
// led7_scan_driver
// Time-multiplexed driver for N_DIGITS common-anode 7-segment digits.
// A prescaler produces one tick every SCAN_DIV clocks; each tick advances the
// digit index and updates the registered segment/anode outputs for the new
// digit on the same edge. New data is written to a shadow register by 'load'
// and is copied into the display register only at the frame boundary (index
// wrap to 0), so a frame never shows a mix of old and new digits.
//
// Parameters:
//   N_DIGITS   : number of digits (1..8)
//   SCAN_DIV   : clocks per digit slot (>= 2)
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   load       : one-cycle strobe capturing value/blank_mask/dp into shadow
//   value      : hex nibbles, nibble k drives digit k
//   blank_mask : bit k forces digit k dark
//   dp         : bit k lights decimal point of digit k
//   seg_n      : active-low segments a..g (registered)
//   dp_n       : active-low decimal point (registered)
//   an_n       : active-low digit enables, at most one low (registered)
//   pending    : shadow holds data not yet committed
//   frame_done : one-cycle pulse on each commit edge
//
// Configuration macro:
//   LED7_LZB_EN : when defined, leading zero digits (from the top digit down
//                 to the first nonzero nibble, never digit 0) are blanked.
// ----------------------------------------------------------------------------
import led7_pkg::*;

module led7_scan_driver #(
    parameter int N_DIGITS = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   blank_mask,
    input  logic [N_DIGITS-1:0]   dp,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic [N_DIGITS-1:0]   an_n,
    output logic                  pending,
    output logic                  frame_done
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int VAL_W = 4 * N_DIGITS;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [VAL_W-1:0]    sh_value_q, sh_value_d;
    logic [N_DIGITS-1:0] sh_blank_q, sh_blank_d;
    logic [N_DIGITS-1:0] sh_dp_q, sh_dp_d;
    logic [VAL_W-1:0]    dsp_value_q, dsp_value_d;
    logic [N_DIGITS-1:0] dsp_blank_q, dsp_blank_d;
    logic [N_DIGITS-1:0] dsp_dp_q, dsp_dp_d;
    logic                pending_q, pending_d;
    logic                frame_done_q, frame_done_d;
    seg_t                seg_n_q, seg_n_d;
    logic                dp_n_q, dp_n_d;
    logic [N_DIGITS-1:0] an_n_q, an_n_d;

    logic                tick;
    logic                commit;
    logic [VAL_W-1:0]    src_value;
    logic [N_DIGITS-1:0] src_blank;
    logic [N_DIGITS-1:0] src_dp;
    logic [N_DIGITS-1:0] lzb_mask;
    logic [N_DIGITS-1:0] an_sel_n;
    nibble_t             sel_nibble;
    logic                sel_dark;
    logic                sel_dp;
    seg_t                glyph_seg;

    // Prescaler, digit index and shadow/display bookkeeping.
    always_comb begin
        tick  = (cnt_q == CNT_LAST);
        cnt_d = tick ? '0 : cnt_q + 1'b1;

        commit = tick && (idx_q == IDX_LAST);
        idx_d  = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        // Display takes the pre-edge shadow; a coincident load still lands
        // in the shadow and keeps pending set.
        dsp_value_d = dsp_value_q;
        dsp_blank_d = dsp_blank_q;
        dsp_dp_d    = dsp_dp_q;
        pending_d   = pending_q;
        if (commit) begin
            dsp_value_d = sh_value_q;
            dsp_blank_d = sh_blank_q;
            dsp_dp_d    = sh_dp_q;
            pending_d   = 1'b0;
        end

        sh_value_d = sh_value_q;
        sh_blank_d = sh_blank_q;
        sh_dp_d    = sh_dp_q;
        if (load) begin
            sh_value_d = value;
            sh_blank_d = blank_mask;
            sh_dp_d    = dp;
            pending_d  = 1'b1;
        end

        frame_done_d = commit;

        // Outputs are computed for the post-edge display contents so they
        // appear on the same edge as the index change.
        src_value = commit ? sh_value_q : dsp_value_q;
        src_blank = commit ? sh_blank_q : dsp_blank_q;
        src_dp    = commit ? sh_dp_q    : dsp_dp_q;
    end

`ifdef LED7_LZB_EN
    logic zero_run;

    // Walk down from the top digit; blanking stops at the first nonzero.
    always_comb begin
        zero_run = 1'b1;
        lzb_mask = '0;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            zero_run    = zero_run && (src_value[4*k +: 4] == 4'h0);
            lzb_mask[k] = zero_run;
        end
    end
`else
    assign lzb_mask = '0;
`endif

    // Select the nibble and attributes of the digit about to be shown.
    always_comb begin
        sel_nibble = '0;
        sel_dark   = 1'b0;
        sel_dp     = 1'b0;
        an_sel_n   = '1;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (idx_d == IDX_W'(k)) begin
                sel_nibble  = src_value[4*k +: 4];
                sel_dark    = src_blank[k] || lzb_mask[k];
                sel_dp      = src_dp[k];
                an_sel_n[k] = 1'b0;
            end
        end
    end

    led7_hex_decode u_hex_decode (
        .nibble (sel_nibble),
        .seg_n  (glyph_seg)
    );

    // Registered display outputs, refreshed only on scan ticks.
    always_comb begin
        seg_n_d = seg_n_q;
        dp_n_d  = dp_n_q;
        an_n_d  = an_n_q;
        if (tick) begin
            if (sel_dark) begin
                seg_n_d = SEG_OFF;
                dp_n_d  = 1'b1;
                an_n_d  = '1;
            end else begin
                seg_n_d = glyph_seg;
                dp_n_d  = ~sel_dp;
                an_n_d  = an_sel_n;
            end
        end
    end

    // State registers. Index resets to the last digit so the first tick
    // after reset is a commit edge showing digit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= IDX_LAST;
            sh_value_q   <= '0;
            sh_blank_q   <= '0;
            sh_dp_q      <= '0;
            dsp_value_q  <= '0;
            dsp_blank_q  <= '0;
            dsp_dp_q     <= '0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            seg_n_q      <= SEG_OFF;
            dp_n_q       <= 1'b1;
            an_n_q       <= '1;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            sh_value_q   <= sh_value_d;
            sh_blank_q   <= sh_blank_d;
            sh_dp_q      <= sh_dp_d;
            dsp_value_q  <= dsp_value_d;
            dsp_blank_q  <= dsp_blank_d;
            dsp_dp_q     <= dsp_dp_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
            seg_n_q      <= seg_n_d;
            dp_n_q       <= dp_n_d;
            an_n_q       <= an_n_d;
        end
    end

    assign seg_n      = seg_n_q;
    assign dp_n       = dp_n_q;
    assign an_n       = an_n_q;
    assign pending    = pending_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_led7_scan_driver.sv
// ----------------------------------------------------------------------------
// tb_led7_scan_driver
// Bench for led7_scan_driver with N_DIGITS=4, SCAN_DIV=4. A small reference
// model of the shadow/display registers pushes the expected output word for
// every scan slot into a queue; each test pops and compares after the slot
// edge. Honors LED7_LZB_EN for the expected leading-zero blanking.
// ----------------------------------------------------------------------------
module tb_led7_scan_driver;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] value;
    logic [3:0]  blank_mask;
    logic [3:0]  dp;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;
    logic        pending;
    logic        frame_done;

    logic [13:0] obs;
    assign obs = {an_n, seg_n, dp_n, pending, frame_done};

    int checks = 0;
    int errors = 0;

    logic [13:0] exp_q[$];

    // Reference model state
    logic [15:0] md_v, ms_v;
    logic [3:0]  md_m, ms_m, md_d, ms_d;
    logic        mp;
    int          midx;

    led7_scan_driver #(.N_DIGITS(4), .SCAN_DIV(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .value      (value),
        .blank_mask (blank_mask),
        .dp         (dp),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .an_n       (an_n),
        .pending    (pending),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [6:0] exp_glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;
            4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;
            4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;
            4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;
            4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic logic lzb_dark(input logic [15:0] v, input int k);
`ifdef LED7_LZB_EN
        if (k == 0) return 1'b0;
        for (int j = k; j < 4; j++) begin
            if (v[4*j +: 4] != 4'h0) return 1'b0;
        end
        return 1'b1;
`else
        return (v[0] && 1'b0) || (k < 0);
`endif
    endfunction

    function automatic void model_reset();
        md_v = '0; md_m = '0; md_d = '0;
        ms_v = '0; ms_m = '0; ms_d = '0;
        mp   = 1'b0;
        midx = 3;
    endfunction

    function automatic void model_load(input logic [15:0] v, input logic [3:0] m, input logic [3:0] d);
        ms_v = v; ms_m = m; ms_d = d;
        mp   = 1'b1;
    endfunction

    // Advance one scan tick; ld marks a load captured on this same edge.
    function automatic void model_tick(input bit ld, input logic [15:0] v, input logic [3:0] m, input logic [3:0] d);
        logic commit;
        logic dark;
        midx   = (midx == 3) ? 0 : midx + 1;
        commit = (midx == 0);
        if (commit) begin
            md_v = ms_v; md_m = ms_m; md_d = ms_d;
            mp   = 1'b0;
        end
        if (ld) model_load(v, m, d);
        dark = md_m[midx] || lzb_dark(md_v, midx);
        if (dark)
            exp_q.push_back({4'hF, 7'h7F, 1'b1, mp, commit});
        else
            exp_q.push_back({~(4'b0001 << midx), exp_glyph(md_v[4*midx +: 4]), ~md_d[midx], mp, commit});
    endfunction

    // One full scan slot (4 clocks); optional load on the first or last cycle.
    task automatic run_slot(input bit early, input bit late, input logic [15:0] v,
                            input logic [3:0] m, input logic [3:0] d);
        if (early) begin value = v; blank_mask = m; dp = d; load = 1'b1; end
        @(posedge clk); #1;
        load = 1'b0;
        if (early) model_load(v, m, d);
        repeat (2) @(posedge clk);
        #1;
        if (late) begin value = v; blank_mask = m; dp = d; load = 1'b1; end
        @(posedge clk); #1;
        load = 1'b0;
        model_tick(late, v, m, d);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load = 1'b0; value = '0; blank_mask = '0; dp = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_state: got %h expected %h", obs, {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_idle_scan();
        logic [13:0] e;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (frame_done !== 1'b0 || an_n !== 4'hF) begin
            errors++;
            $display("[TB] FAIL idle_pre_tick: got fd=%b an=%h expected fd=0 an=f", frame_done, an_n);
        end
        @(posedge clk); #1;
        model_tick(1'b0, '0, '0, '0);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("[TB] FAIL idle_first_commit: got %h expected %h", obs, e);
        end
        checks++;
        if (seg_n !== 7'h40 || an_n !== 4'hE || frame_done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL idle_first_digit: got seg=%h an=%h fd=%b expected seg=40 an=e fd=1", seg_n, an_n, frame_done);
        end
        @(posedge clk); #1;
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_fd_pulse: got %b expected 0", frame_done);
        end
        repeat (3) @(posedge clk);
        #1;
        model_tick(1'b0, '0, '0, '0);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("[TB] FAIL idle_slot1: got %h expected %h", obs, e);
        end
        for (int i = 0; i < 3; i++) begin
            run_slot(1'b0, 1'b0, '0, '0, '0);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("[TB] FAIL idle_slot%0d: got %h expected %h", i + 2, obs, e);
            end
        end
    endtask

    task automatic test_load_commit();
        logic [13:0] e;
        for (int i = 0; i < 8; i++) begin
            run_slot(i == 0, 1'b0, 16'h12AF, 4'h0, 4'h0);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("[TB] FAIL load_commit slot%0d: got %h expected %h", i, obs, e);
            end
            if (i == 3 || i == 6) begin
                checks++;
                if (seg_n !== ((i == 3) ? 7'h0E : 7'h79) || pending !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL load_commit_glyph slot%0d: got seg=%h pend=%b expected seg=%h pend=0",
                             i, seg_n, pending, (i == 3) ? 7'h0E : 7'h79);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [13:0] e;
        logic [15:0] v;
        for (int i = 0; i < 11; i++) begin
            v = (i == 0) ? 16'h9999 : (i == 1) ? 16'h5555 : 16'h0001;
            run_slot(i < 2, i == 3, v, 4'h0, 4'h0);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("[TB] FAIL back_to_back slot%0d: got %h expected %h", i, obs, e);
            end
            if (i == 3 || i == 7) begin
                checks++;
                if (seg_n !== ((i == 3) ? 7'h12 : 7'h79) || pending !== (i == 3)) begin
                    errors++;
                    $display("[TB] FAIL back_to_back_commit slot%0d: got seg=%h pend=%b", i, seg_n, pending);
                end
            end
        end
    endtask

    task automatic test_blank_dp();
        logic [13:0] e;
        for (int i = 0; i < 5; i++) begin
            run_slot(i == 0, 1'b0, 16'h8888, 4'b0100, 4'b0110);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("[TB] FAIL blank_dp slot%0d: got %h expected %h", i, obs, e);
            end
            if (i == 2) begin
                checks++;
                if (an_n !== 4'hF || seg_n !== 7'h7F || dp_n !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL blank_digit2: got an=%h seg=%h dp=%b expected an=f seg=7f dp=1", an_n, seg_n, dp_n);
                end
            end
        end
    endtask

    task automatic test_lzb();
        logic [13:0] e;
        for (int i = 0; i < 7; i++) begin
            run_slot(i == 0, 1'b0, 16'h0030, 4'h0, 4'b1000);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("[TB] FAIL lzb slot%0d: got %h expected %h", i, obs, e);
            end
        end
`ifdef LED7_LZB_EN
        checks++;
        if (an_n !== 4'hF || seg_n !== 7'h7F || dp_n !== 1'b1) begin
            errors++;
            $display("[TB] FAIL lzb_digit3: got an=%h seg=%h dp=%b expected an=f seg=7f dp=1", an_n, seg_n, dp_n);
        end
`else
        checks++;
        if (an_n !== 4'h7 || seg_n !== 7'h40 || dp_n !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lzb_digit3: got an=%h seg=%h dp=%b expected an=7 seg=40 dp=0", an_n, seg_n, dp_n);
        end
`endif
    endtask

    task automatic test_reset_mid();
        logic [13:0] e;
        value = 16'h4321; blank_mask = '0; dp = '0; load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        checks++;
        if (pending !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_mid_pending_before: got %b expected 1", pending);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_mid_async: got %h expected %h", obs, {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0});
        end
        exp_q.delete();
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            run_slot(1'b0, 1'b0, '0, '0, '0);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("[TB] FAIL reset_mid slot%0d: got %h expected %h", i, obs, e);
            end
            if (i == 0) begin
                checks++;
                if (seg_n !== 7'h40 || an_n !== 4'hE || frame_done !== 1'b1 || pending !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL reset_mid_restart: got seg=%h an=%h fd=%b pend=%b", seg_n, an_n, frame_done, pending);
                end
            end
        end
    endtask

    initial begin
        $display("[TB] led7_scan_driver bench start");
        test_reset();
        test_idle_scan();
        test_load_commit();
        test_back_to_back();
        test_blank_dp();
        test_lzb();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
